// File: rtl/twos_comp_seq.sv
// Bit-serial two's-complement engine: LSB-first copy-until-first-one, invert after.
// Optional COMP_OVF_FLAG_EN adds the ovf port flagging the most negative operand.
module twos_comp_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] OUT,
  output logic             busy,
`ifdef COMP_OVF_FLAG_EN
  output logic             ovf,
`endif
  output logic             done
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] res;
  logic             seen;
  logic [CW-1:0]    cnt;
  logic             rbit_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rbit_c    = sr[0] ^ seen;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == CW'(WIDTH - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs; OUT only moves when leaving DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr   <= '0;
      res  <= '0;
      seen <= 1'b0;
      cnt  <= '0;
      OUT  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
`ifdef COMP_OVF_FLAG_EN
      ovf  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sr   <= A;
            seen <= 1'b0;
            cnt  <= '0;
            busy <= 1'b1;
          end
        end
        SHIFT: begin
          res  <= {rbit_c, res[WIDTH-1:1]};
          sr   <= sr >> 1;
          seen <= seen | sr[0];
          cnt  <= cnt + CW'(1);
        end
        DONE: begin
          OUT  <= res;
          done <= 1'b1;
          busy <= 1'b0;
`ifdef COMP_OVF_FLAG_EN
          // Only 0 and the most negative value negate to themselves; 0 never yields MIN_NEG.
          ovf  <= (res == MIN_NEG);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_twos_comp_seq.sv
// Scoreboard bench for twos_comp_seq: WIDTH=4 and WIDTH=8 instances side by side.
module tb_twos_comp_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start4, start8;
  logic [3:0] a4, out4;
  logic [7:0] a8, out8;
  logic       busy4, done4, ovf4;
  logic       busy8, done8, ovf8;

  int vectors = 0;
  int miscompares = 0;

  logic [4:0] q4[$];
  logic [8:0] q8[$];

  always #5 clk = ~clk;

  twos_comp_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .A(a4), .OUT(out4), .busy(busy4),
`ifdef COMP_OVF_FLAG_EN
    .ovf(ovf4),
`endif
    .done(done4)
  );

  twos_comp_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .OUT(out8), .busy(busy8),
`ifdef COMP_OVF_FLAG_EN
    .ovf(ovf8),
`endif
    .done(done8)
  );

`ifndef COMP_OVF_FLAG_EN
  assign ovf4 = 1'b0;
  assign ovf8 = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Monitors: pop one expectation per done pulse.
  always @(negedge clk) begin
    if (!rst && done4) begin
      if (q4.size() == 0) flag("unexpected_done4");
      else begin
        logic [4:0] e;
        e = q4.pop_front();
        check("out4", 32'(out4), 32'(e[3:0]));
`ifdef COMP_OVF_FLAG_EN
        check("ovf4", 32'(ovf4), 32'(e[4]));
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done8) begin
      if (q8.size() == 0) flag("unexpected_done8");
      else begin
        logic [8:0] e;
        e = q8.pop_front();
        check("out8", 32'(out8), 32'(e[7:0]));
`ifdef COMP_OVF_FLAG_EN
        check("ovf8", 32'(ovf8), 32'(e[8]));
`endif
      end
    end
  end

  task automatic wait_done4(output int cyc);
    bit got = 1'b0;
    cyc = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      cyc++;
      if (done4) got = 1'b1;
    end
    if (!got) flag("timeout_done4");
  endtask

  task automatic wait_done8(output int cyc);
    bit got = 1'b0;
    cyc = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      cyc++;
      if (done8) got = 1'b1;
    end
    if (!got) flag("timeout_done8");
  endtask

  task automatic do_op4(input logic [3:0] a, input logic [3:0] e, input logic eo);
    int cyc;
    @(negedge clk);
    a4 = a; start4 = 1'b1;
    q4.push_back({eo, e});
    @(negedge clk);
    start4 = 1'b0; a4 = ~a;
    wait_done4(cyc);
    check("latency4", 32'(cyc), 32'd5);
  endtask

  task automatic do_op8(input logic [7:0] a, input logic [7:0] e, input logic eo);
    int cyc;
    @(negedge clk);
    a8 = a; start8 = 1'b1;
    q8.push_back({eo, e});
    @(negedge clk);
    start8 = 1'b0; a8 = ~a;
    wait_done8(cyc);
    check("latency8", 32'(cyc), 32'd9);
  endtask

  logic [3:0] sweep_exp [16] = '{4'h0, 4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9,
                                 4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};

  initial begin
    int cyc;
    int ndone;
    rst = 1'b1; start4 = 1'b0; start8 = 1'b0; a4 = '0; a8 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_out4", 32'(out4), 32'd0);
    check("rst_busy4", 32'(busy4), 32'd0);
    check("rst_done4", 32'(done4), 32'd0);
    check("rst_ovf4", 32'(ovf4), 32'd0);
    check("rst_out8", 32'(out8), 32'd0);

    // First op with cycle-by-cycle busy/done timing.
    @(negedge clk);
    a4 = 4'b0011; start4 = 1'b1;
    q4.push_back({1'b0, 4'b1101});
    @(negedge clk);
    start4 = 1'b0; a4 = 4'b1111;
    check("busy_edge0", 32'(busy4), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("busy_mid", 32'(busy4), 32'd1);
      check("done_mid", 32'(done4), 32'd0);
    end
    @(negedge clk);
    check("done_pulse", 32'(done4), 32'd1);
    check("busy_drop", 32'(busy4), 32'd0);
    @(negedge clk);
    check("done_single", 32'(done4), 32'd0);
    check("out_held", 32'(out4), 32'hD);

    // Reset pulse while idle clears the held result.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_idle_out4", 32'(out4), 32'd0);

    for (int i = 0; i < 16; i++)
      do_op4(4'(i), sweep_exp[i], (i == 8));

    do_op4(4'b1000, 4'b1000, 1'b1);
    do_op4(4'b0101, 4'b1011, 1'b0);

    // start held high through SHIFT/DONE: exactly one extra accept at edge WIDTH+2.
    @(negedge clk);
    a4 = 4'b0011; start4 = 1'b1;
    q4.push_back({1'b0, 4'b1101});
    q4.push_back({1'b0, 4'b1010});
    @(negedge clk);
    a4 = 4'b0110;
    wait_done4(cyc);
    check("hold_lat1", 32'(cyc), 32'd5);
    wait_done4(cyc);
    check("hold_lat2", 32'(cyc), 32'd6);
    start4 = 1'b0;
    repeat (8) @(negedge clk);

    // Abort mid-SHIFT.
    @(negedge clk);
    a4 = 4'b0101; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_out4", 32'(out4), 32'd0);
    check("abort_busy4", 32'(busy4), 32'd0);
    check("abort_done4", 32'(done4), 32'd0);
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done4) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    do_op4(4'b0111, 4'b1001, 1'b0);

    do_op8(8'h01, 8'hFF, 1'b0);
    do_op8(8'h80, 8'h80, 1'b1);
    do_op8(8'h5A, 8'hA6, 1'b0);

    repeat (4) @(negedge clk);
    check("q4_drained", 32'(q4.size()), 32'd0);
    check("q8_drained", 32'(q8.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/twos_comp_seq.md
# twos_comp_seq

Bit-serial two's-complement engine with a start/done handshake. It sequences a one-bit complement datapath over a WIDTH-bit operand, LSB first: each bit is copied up to and including the first 1, and every bit after that is inverted. It sits beside the combinational complement path as its area-reduced, multi-cycle counterpart, and is driven by a host that issues one operation at a time.

## Interface
- WIDTH, 4: operand and result width in bits (≥2).
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on clk rising edge only in IDLE.
- A  input  WIDTH  operand; captured in the cycle start is accepted.
- OUT  output  WIDTH  registered result; holds last result until the next accepted start completes.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when OUT is valid.
- ovf  output  1  present only with COMP_OVF_FLAG_EN (see Configuration).

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: busy=0, done=0. If start=1 at the edge: load shift register ← A, seen ← 0, bit counter ← 0, go to SHIFT. Otherwise stay.
- SHIFT: each cycle takes b = sr[0]; result bit = b ^ seen; seen ← seen | b. The result bit enters the MSB of the result shift register, sr shifts right, and the counter increments. After WIDTH bits (counter = WIDTH-1 on that edge), go to DONE.
- DONE: OUT ← assembled result, done=1 for this single cycle, busy=0. Next state is IDLE unconditionally.
- Arithmetic: the result is (~A + 1) mod 2^WIDTH. A=0 gives 0. A=100…0 gives itself.
- Counter width: ceil(log2(WIDTH)), minimum 1.
- start asserted while busy or in DONE is ignored; it does not queue. A is not sampled outside acceptance.
- rst asserted at any time, including mid-SHIFT: all state clears immediately and the in-flight operation is discarded with no done pulse.

## Timing
- Reset values: OUT=0, busy=0, done=0, ovf=0, state=IDLE, seen=0, counter=0.
- Edge 0 accepts start (IDLE→SHIFT); busy=1 after edge 0.
- Edges 1..WIDTH process bits 0..WIDTH-1; the edge after the final bit enters DONE.
- done=1 and the new OUT are visible after edge WIDTH+1. busy drops in the same cycle.
- Earliest next accept: edge WIDTH+2, so back-to-back throughput is one operation per WIDTH+2 cycles.
- OUT changes only on entry to DONE or on rst.

## Configuration
- COMP_OVF_FLAG_EN defined:
  - Port ovf exists.
  - In DONE, ovf ← 1 iff the captured A was 1 followed by WIDTH-1 zeros (the most negative value, whose negation is not representable). Otherwise ovf ← 0.
  - ovf is held with OUT and cleared by rst.
- COMP_OVF_FLAG_EN undefined:
  - No ovf port and no associated logic.
  - All other behaviour is identical.

## Test plan
- rst pulse mid-idle → OUT=0000, busy=0, done=0. Then A=0011 with start for one cycle → done pulses exactly 5 cycles later with OUT=1101, and busy is high for the 4 cycles in between.
- Sweep A=0000..1111 (WIDTH=4), each awaited to done → OUT equals (16-A)%16 for every value, e.g. 0001→1111, 0110→1010, 0000→0000.
- A=1000 → OUT=1000. With COMP_OVF_FLAG_EN, ovf=1; the next operation with A=0101 gives OUT=1011, ovf=0.
- Accept A=0011, then hold start=1 with A=0110 during SHIFT/DONE → the first result is 1101. The second operation is accepted only at edge WIDTH+2 (start still high, A=0110), giving OUT=1010; no start is lost or duplicated.
- Accept A=0101, assert rst after 2 SHIFT cycles, then release → no done pulse, OUT=0000, state IDLE. A fresh start with A=0111 gives OUT=1001.
- Re-elaborate with WIDTH=8, A=8'h01 → OUT=8'hFF after 9 cycles. A=8'h80 → OUT=8'h80, and ovf=1 when enabled.
